uart_tx_fifo: RTL and testbench

Buffered 8N1 UART transmitter. It is the transmit-side counterpart of the accelerator's UART receiver, and it returns result bytes from top_DNNAcc to the host over TxD. Bytes are pushed through a strobe interface into a small FIFO. A bit-timing FSM serialises them LSB-first, with one start bit and one stop bit, and back-to-back frames are supported.

---
 rtl/uart_pkg.sv | 14 +
 rtl/sync_fifo.sv | 55 +++++
 rtl/uart_tx_fifo.sv | 154 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit and receive paths.
package uart_pkg;

    localparam int UART_DATA_BITS       = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 104;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an occupancy count; a write into a full FIFO is kept
// when a pop happens on the same edge, because the popped slot is the one written.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             wr_drop
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_rd;
    logic             do_wr;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign wr_drop = wr_en && !do_wr;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a bit-timing FSM, LSB first.
//   state | meaning
//   IDLE  | line high, waiting for a queued byte
//   START | start bit (line low) for one bit time
//   DATA  | shifting out the 8 data bits, one bit time each
//   STOP  | stop bit (line high); chains straight into START if bytes remain
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 8,
    parameter int CNT_W        = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       TxData,
    input  logic             isNewTxData,
    output logic             TxD,
    output logic             isBusy,
    output logic             isFull,
    output logic             txDone,
    output logic             overflow,
    output logic [CNT_W-1:0] fifoCount
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(UART_DATA_BITS);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(UART_DATA_BITS - 1);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_START = START;
    localparam logic [1:0] ST_DATA  = DATA;
    localparam logic [1:0] ST_STOP  = STOP;

    logic [1:0]                state;
    logic [BAUD_W-1:0]         baud_cnt;
    logic [BIT_W-1:0]          bit_idx;
    logic [UART_DATA_BITS-1:0] shift_reg;
    logic                      tx_reg;
    logic                      done_reg;
    logic                      ovf_reg;

    logic [7:0] fifo_head;
    logic       fifo_empty;
    logic       fifo_full;
    logic       fifo_pop;
    logic       wr_drop;
    logic       bit_end;

    assign bit_end  = (baud_cnt == BAUD_LAST);
    // Pop either from idle or on the final stop-bit cycle for gapless frames.
    assign fifo_pop = !fifo_empty &&
                      ((state == ST_IDLE) || ((state == ST_STOP) && bit_end));

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .wr_en   (isNewTxData),
        .wr_data (TxData),
        .rd_en   (fifo_pop),
        .rd_data (fifo_head),
        .count   (fifoCount),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .wr_drop (wr_drop)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx_reg    <= 1'b1;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state)
                ST_IDLE: begin
                    baud_cnt <= '0;
                    tx_reg   <= 1'b1;
                    if (fifo_pop) begin
                        shift_reg <= fifo_head;
                        state     <= ST_START;
                        tx_reg    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= ST_DATA;
                        tx_reg   <= shift_reg[0];
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == BIT_LAST) begin
                            state  <= ST_STOP;
                            tx_reg <= 1'b1;
                        end else begin
                            shift_reg <= {1'b0, shift_reg[UART_DATA_BITS-1:1]};
                            tx_reg    <= shift_reg[1];
                            bit_idx   <= bit_idx + BIT_W'(1);
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        done_reg <= 1'b1;
                        if (fifo_pop) begin
                            shift_reg <= fifo_head;
                            state     <= ST_START;
                            tx_reg    <= 1'b0;
                        end else begin
                            state  <= ST_IDLE;
                            tx_reg <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    tx_reg <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        ovf_reg <= 1'b0;
        else if (wr_drop) ovf_reg <= 1'b1;
    end

    assign TxD      = tx_reg;
    assign txDone   = done_reg;
    assign overflow = ovf_reg;
    assign isFull   = fifo_full;
    assign isBusy   = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at 4 clocks per bit with an 8-entry FIFO.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] TxData = 8'h00;
    logic       isNewTxData = 1'b0;
    logic       TxD;
    logic       isBusy;
    logic       isFull;
    logic       txDone;
    logic       overflow;
    logic [3:0] fifoCount;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (8),
        .CNT_W        (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .TxData      (TxData),
        .isNewTxData (isNewTxData),
        .TxD         (TxD),
        .isBusy      (isBusy),
        .isFull      (isFull),
        .txDone      (txDone),
        .overflow    (overflow),
        .fifoCount   (fifoCount)
    );

    // Reference serial receiver: detects the start edge, samples each bit mid-period.
    logic       rx_act;
    int         rx_cnt;
    logic [7:0] rx_sh;
    logic [7:0] rx_q[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_act <= 1'b0;
            rx_cnt <= 0;
            rx_sh  <= 8'h00;
            rx_q.delete();
        end else if (!rx_act) begin
            if (TxD === 1'b0) begin
                rx_act <= 1'b1;
                rx_cnt <= 1;
            end
        end else begin
            rx_cnt <= rx_cnt + 1;
            if (rx_cnt >= CPB + CPB/2 && rx_cnt <= 8*CPB + CPB/2 && (rx_cnt % CPB) == CPB/2)
                rx_sh <= {TxD, rx_sh[7:1]};
            else if (rx_cnt == 9*CPB + CPB/2) begin
                rx_act <= 1'b0;
                if (TxD === 1'b1) rx_q.push_back(rx_sh);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        isNewTxData = 1'b0;
        repeat (2) step();
        reset = 1'b0;
    endtask

    // Expected line level on cycle c (1-based) of a frame carrying byte b.
    function automatic logic exp_txd(input logic [7:0] b, input int c);
        int bit_n;
        bit_n = (c - 1) / CPB;
        if (bit_n == 0) return 1'b0;
        if (bit_n >= 9) return 1'b1;
        return b[bit_n - 1];
    endfunction

    function automatic logic [7:0] rx_at(input int i);
        if (i < rx_q.size()) return rx_q[i];
        return 8'hxx;
    endfunction

    initial begin
        logic [7:0] lb [3];
        logic       e;
        int         bad;

        // reset state
        reset = 1'b1;
        #2;
        chk("rst_txd", TxD, 1);
        chk("rst_busy", isBusy, 0);
        chk("rst_full", isFull, 0);
        chk("rst_done", txDone, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_cnt", fifoCount, 0);
        do_reset();

        // single byte 0xA5
        TxData = 8'hA5;
        isNewTxData = 1'b1;
        step();
        isNewTxData = 1'b0;
        chk("single_cnt_after_wr", fifoCount, 1);
        chk("single_txd_before_pop", TxD, 1);
        for (int c = 1; c <= 44; c++) begin
            step();
            e = (c <= FRAME) ? exp_txd(8'hA5, c) : 1'b1;
            chk($sformatf("single_txd_c%0d", c), TxD, e);
            chk($sformatf("single_busy_c%0d", c), isBusy, (c <= FRAME));
            chk($sformatf("single_done_c%0d", c), txDone, (c == FRAME + 1));
            if (c == 1) chk("single_cnt_after_pop", fifoCount, 0);
        end

        // back-to-back 0x00 then 0xFF
        do_reset();
        TxData = 8'h00;
        isNewTxData = 1'b1;
        step();
        TxData = 8'hFF;
        for (int c = 1; c <= 2*FRAME + 4; c++) begin
            step();
            if (c == 1) isNewTxData = 1'b0;
            if (c <= FRAME)        e = exp_txd(8'h00, c);
            else if (c <= 2*FRAME) e = exp_txd(8'hFF, c - FRAME);
            else                   e = 1'b1;
            chk($sformatf("b2b_txd_c%0d", c), TxD, e);
            chk($sformatf("b2b_busy_c%0d", c), isBusy, (c <= 2*FRAME));
            chk($sformatf("b2b_done_c%0d", c), txDone, (c == FRAME + 1 || c == 2*FRAME + 1));
        end

        // overflow: 10 writes into an 8-deep FIFO
        do_reset();
        for (int i = 0; i < 10; i++) begin
            TxData = 8'h30 + 8'(i);
            isNewTxData = 1'b1;
            step();
            if (i == 8) begin
                chk("ovf_cnt_e8", fifoCount, 8);
                chk("ovf_full_e8", isFull, 1);
                chk("ovf_flag_e8", overflow, 0);
            end
            if (i == 9) begin
                chk("ovf_cnt_e9", fifoCount, 8);
                chk("ovf_flag_e9", overflow, 1);
            end
        end
        isNewTxData = 1'b0;
        repeat (9*FRAME + 20) step();
        chk("ovf_frames", rx_q.size(), 9);
        for (int i = 0; i < 9; i++) chk($sformatf("ovf_byte%0d", i), rx_at(i), 8'h30 + 8'(i));
        chk("ovf_sticky", overflow, 1);
        chk("ovf_cnt_drained", fifoCount, 0);

        // write accepted while full on the edge that ends STOP
        do_reset();
        for (int i = 0; i < 9; i++) begin
            TxData = 8'h50 + 8'(i);
            isNewTxData = 1'b1;
            step();
        end
        isNewTxData = 1'b0;
        repeat (32) step();
        chk("wfp_cnt_pre", fifoCount, 8);
        chk("wfp_done_pre", txDone, 0);
        TxData = 8'h59;
        isNewTxData = 1'b1;
        step();
        isNewTxData = 1'b0;
        chk("wfp_done", txDone, 1);
        chk("wfp_cnt", fifoCount, 8);
        chk("wfp_full", isFull, 1);
        chk("wfp_ovf", overflow, 0);
        chk("wfp_txd_start", TxD, 0);
        repeat (9*FRAME + 20) step();
        chk("wfp_frames", rx_q.size(), 10);
        for (int i = 0; i < 10; i++) chk($sformatf("wfp_byte%0d", i), rx_at(i), 8'h50 + 8'(i));

        // reset during DATA bit 3 with 3 bytes queued
        do_reset();
        for (int i = 0; i < 4; i++) begin
            TxData = 8'hC0 + 8'(i);
            isNewTxData = 1'b1;
            step();
        end
        isNewTxData = 1'b0;
        repeat (15) step();
        chk("mid_busy", isBusy, 1);
        chk("mid_cnt", fifoCount, 3);
        chk("mid_txd_bit3", TxD, 1'b0);
        reset = 1'b1;
        #1;
        chk("mid_rst_txd", TxD, 1);
        chk("mid_rst_cnt", fifoCount, 0);
        chk("mid_rst_busy", isBusy, 0);
        #1;
        reset = 1'b0;
        bad = 0;
        repeat (60) begin
            step();
            if (TxD !== 1'b1 || isBusy !== 1'b0) bad++;
        end
        chk("mid_quiet_cycles", bad, 0);
        chk("mid_quiet_frames", rx_q.size(), 0);

        // loopback through the reference receiver
        lb[0] = 8'h3C;
        lb[1] = 8'h81;
        lb[2] = 8'h7E;
        for (int i = 0; i < 3; i++) begin
            TxData = lb[i];
            isNewTxData = 1'b1;
            step();
        end
        isNewTxData = 1'b0;
        repeat (3*FRAME + 10) step();
        chk("lb_frames", rx_q.size(), 3);
        for (int i = 0; i < 3; i++) chk($sformatf("lb_byte%0d", i), rx_at(i), lb[i]);
        chk("lb_idle_txd", TxD, 1);
        chk("lb_idle_busy", isBusy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
